// File: rtl/noc_axi_req_scheduler_if.sv
// Bundled AR/AW request, per-beat command, type-FIFO and credit signals of the
// NoC request scheduler. The slave modport is the scheduler's view.
interface noc_axi_req_scheduler_if #(
    parameter int AXI_ADDR_WIDTH = 64
);
    logic                      s_axi_arvalid;
    logic                      s_axi_arready;
    logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
    logic [7:0]                s_axi_arlen;
    logic                      s_axi_awvalid;
    logic                      s_axi_awready;
    logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic [7:0]                s_axi_awlen;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic                      cmd_last;
    logic                      type_wr;
    logic [5:0]                type_wr_data;
    logic                      l2_request_ack;
    logic                      previous_trans_complete;
    logic                      busy;

    modport slave (
        input  s_axi_arvalid, s_axi_araddr, s_axi_arlen,
        input  s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
        input  cmd_ready, l2_request_ack, previous_trans_complete,
        output s_axi_arready, s_axi_awready,
        output cmd_valid, cmd_write, cmd_addr, cmd_last,
        output type_wr, type_wr_data, busy
    );

    modport master (
        output s_axi_arvalid, s_axi_araddr, s_axi_arlen,
        output s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
        output cmd_ready, l2_request_ack, previous_trans_complete,
        input  s_axi_arready, s_axi_awready,
        input  cmd_valid, cmd_write, cmd_addr, cmd_last,
        input  type_wr, type_wr_data, busy
    );
endinterface

// File: rtl/noc_axi_req_scheduler.sv
// Splits AXI AR/AW bursts into per-beat NoC request commands, pushes one type
// entry per beat, and throttles issue with L2 data-ack credits.
module noc_axi_req_scheduler #(
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    noc_axi_req_scheduler_if.slave           bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam int              STRIDE_SHIFT = (AXI_DATA_WIDTH == 128) ? 4 : 3;
    localparam logic [4:0]      MAX_OUT      = 5'(MAX_OUTSTANDING);

    state_t                    state_r;
    state_t                    state_s;
    logic                      en_r;
    logic                      last_dir_r;
    logic                      dir_r;
    logic [AXI_ADDR_WIDTH-1:0] start_addr_r;
    logic [7:0]                len_r;
    logic [7:0]                beat_r;
    logic [4:0]                outstanding_r;
    logic                      hold_r;

    logic                      cand_valid_s;
    logic                      cand_write_s;
    logic                      drained_s;
    logic                      need_drain_s;
    logic                      grant_s;
    logic                      issue_s;
    logic                      cmd_valid_s;
    logic                      fire_s;
    logic                      last_beat_s;
    logic                      ack_s;
    logic [AXI_ADDR_WIDTH-1:0] beat_addr_s;

    // Type entry: [5] store-last, [4] load-last, [3] 128-bit beat,
    // [2] upper 64-bit half for 64-bit beats, [1:0] 1=load / 2=store.
    function automatic logic [5:0] type_entry(input logic is_write,
                                              input logic is_last,
                                              input logic addr_bit3);
        logic [5:0] e;
        e[5]   = is_write & is_last;
        e[4]   = ~is_write & is_last;
        e[3]   = (AXI_DATA_WIDTH == 128) ? 1'b1 : 1'b0;
        e[2]   = (AXI_DATA_WIDTH == 64) ? addr_bit3 : 1'b0;
        e[1:0] = is_write ? 2'd2 : 2'd1;
        return e;
    endfunction

    function automatic logic [AXI_ADDR_WIDTH-1:0] beat_address(
        input logic [AXI_ADDR_WIDTH-1:0] base,
        input logic [7:0]                beat);
        return base + (AXI_ADDR_WIDTH'(beat) << STRIDE_SHIFT);
    endfunction

    // Arbitration: round-robin on contention, drain before a direction change.
    always_comb begin
        cand_valid_s = bus.s_axi_arvalid | bus.s_axi_awvalid;
        if (bus.s_axi_arvalid && bus.s_axi_awvalid) begin
            cand_write_s = ~last_dir_r;
        end else if (bus.s_axi_awvalid) begin
            cand_write_s = 1'b1;
        end else begin
            cand_write_s = 1'b0;
        end
        drained_s    = (outstanding_r == 5'd0) && bus.previous_trans_complete;
        need_drain_s = cand_valid_s && (cand_write_s != last_dir_r) && !drained_s;
        grant_s      = en_r && (state_r == ST_IDLE) && cand_valid_s && !need_drain_s;
    end

    // Per-beat command datapath and credit gating.
    always_comb begin
        issue_s     = (state_r == ST_ISSUE);
        cmd_valid_s = issue_s && ((outstanding_r < MAX_OUT) || hold_r);
        fire_s      = cmd_valid_s && bus.cmd_ready;
        last_beat_s = (beat_r == len_r);
        ack_s       = bus.l2_request_ack && (outstanding_r != 5'd0);
        beat_addr_s = beat_address(start_addr_r, beat_r);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_s = ST_ISSUE;
                end else if (en_r && need_drain_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drained_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_ISSUE: begin
                if (fire_s && last_beat_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register; en_r keeps the ready outputs low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            en_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            en_r    <= 1'b1;
        end
    end

    // Burst capture and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dir_r   <= 1'b0;
            dir_r        <= 1'b0;
            start_addr_r <= '0;
            len_r        <= 8'd0;
            beat_r       <= 8'd0;
        end else if (grant_s) begin
            last_dir_r   <= cand_write_s;
            dir_r        <= cand_write_s;
            start_addr_r <= cand_write_s ? bus.s_axi_awaddr : bus.s_axi_araddr;
            len_r        <= cand_write_s ? bus.s_axi_awlen : bus.s_axi_arlen;
            beat_r       <= 8'd0;
        end else if (fire_s) begin
            beat_r       <= beat_r + 8'd1;
        end else begin
            beat_r       <= beat_r;
        end
    end

    // Outstanding credit counter; simultaneous issue and ack cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_r <= 5'd0;
        end else begin
            case ({fire_s, ack_s})
                2'b10:   outstanding_r <= outstanding_r + 5'd1;
                2'b01:   outstanding_r <= outstanding_r - 5'd1;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Keeps an offered command valid until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= 1'b0;
        end else begin
            hold_r <= cmd_valid_s && !bus.cmd_ready;
        end
    end

    assign bus.s_axi_arready = grant_s && !cand_write_s;
    assign bus.s_axi_awready = grant_s && cand_write_s;
    assign bus.cmd_valid     = cmd_valid_s;
    assign bus.cmd_write     = issue_s && dir_r;
    assign bus.cmd_addr      = issue_s ? beat_addr_s : '0;
    assign bus.cmd_last      = issue_s && last_beat_s;
    assign bus.type_wr       = fire_s;
    assign bus.type_wr_data  = fire_s ? type_entry(dir_r, last_beat_s, beat_addr_s[3]) : 6'd0;
    assign bus.busy          = (state_r != ST_IDLE) || (outstanding_r != 5'd0);

endmodule
